// File: rtl/adder_scheduler.sv
// Purpose: shares one N-bit ripple adder slice between two requesters, summing N*W-bit operands LSB slice first.
// Latency: W cycles from request handshake to rsp_valid; one DONE and one IDLE cycle between operations.
// Backpressure: the response holds in DONE until rsp_ready; no request is accepted outside IDLE.
module adder_scheduler #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N*W-1:0] req0_a,
    input  logic [N*W-1:0] req0_b,
    input  logic           req0_cin,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N*W-1:0] req1_a,
    input  logic [N*W-1:0] req1_b,
    input  logic           req1_cin,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N*W-1:0] rsp_sum,
    output logic           rsp_carry,
    output logic           rsp_id,
    output logic           busy
);
    localparam int DW = N * W;
    localparam int KW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   a_reg;
    logic [DW-1:0]   b_reg;
    logic [DW-1:0]   sum_reg;
    logic            carry_reg;
    logic [KW-1:0]   k;
    logic            id_reg;
    logic            prio;
    logic            grant0;
    logic            grant1;
    logic            accept;
    logic            last_slice;
    int              base;
    logic [N-1:0]    slice_a;
    logic [N-1:0]    slice_b;
    logic [N-1:0]    slice_sum;
    logic            slice_co;

    // prio == 0 favours requester 0 when both are valid
    always_comb begin
        grant0     = req0_valid && (!req1_valid || !prio);
        grant1     = req1_valid && (!req0_valid || prio);
        req0_ready = rst_n && (state == IDLE) && grant0;
        req1_ready = rst_n && (state == IDLE) && grant1;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        base       = int'(k) * N;
        last_slice = (k == KW'(W - 1));
        slice_a    = a_reg[base +: N];
        slice_b    = b_reg[base +: N];
        {slice_co, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{N{1'b0}}, carry_reg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (rsp_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
            id_reg    <= 1'b0;
            prio      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= req1_ready ? req1_a   : req0_a;
                        b_reg     <= req1_ready ? req1_b   : req0_b;
                        carry_reg <= req1_ready ? req1_cin : req0_cin;
                        sum_reg   <= '0;
                        k         <= '0;
                        id_reg    <= req1_ready;
                        // hand priority to whichever requester was not served
                        prio      <= req0_ready;
                    end
                end
                RUN: begin
                    sum_reg[base +: N] <= slice_sum;
                    carry_reg          <= slice_co;
                    if (!last_slice) begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_sum   = sum_reg;
    assign rsp_carry = carry_reg;
    assign rsp_id    = id_reg;
    assign busy      = (state != IDLE);

endmodule
